// File: rtl/ram_reader_if.sv
// ----------------------------------------------------------------------------
// ram_reader_if
// Output stream of the RAM read-back engine: one word plus its RAM address,
// transferred when out_valid && out_ready.
//   out_data  : streamed RAM word
//   out_addr  : RAM address the word was read from
//   out_valid : out_data/out_addr hold a word
//   out_ready : consumer accepts the word this cycle
// master = ram_reader (producer), slave = consumer.
// ----------------------------------------------------------------------------
interface ram_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_addr, output out_valid,
                  input  out_ready);
  modport slave  (input  out_data, input  out_addr, input  out_valid,
                  output out_ready);
endinterface

// File: rtl/ram_reader.sv
// ----------------------------------------------------------------------------
// ram_reader
// Sequential read-back engine for the on-chip program/data RAM. On Start it
// reads addresses 0..WORDS-1 in order and streams every word out on a
// valid/ready interface. Reads are issued only while the output buffer has
// room for every read still in flight, so backpressure never drops or
// duplicates a word.
//
// Ports:
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   Start        : single-cycle pulse, begins a pass when idle
//   ADDR, rden   : RAM read address / read enable
//   q            : RAM read data, valid RD_LAT cycles after rden
//   out_if       : output stream (out_data, out_addr, out_valid, out_ready)
//   busy         : pass in progress (READ or DRAIN)
//   done         : one-cycle pulse after the last word is accepted
//   checksum     : running sum of accepted words
//
// Optional feature macro: RAM_READER_CHECKSUM_EN
//   defined   -> checksum accumulates every accepted word mod 2^DATA_W,
//                cleared on Start, held after done
//   undefined -> checksum tied to 0, no adder
// ----------------------------------------------------------------------------
module ram_reader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WORDS     = 256,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  output logic [ADDR_W-1:0] ADDR,
  output logic              rden,
  input  logic [DATA_W-1:0] q,
  ram_reader_if.master      out_if,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [ADDR_W-1:0] tag_addr_q [RD_LAT];
  logic [ADDR_W-1:0] tag_addr_d [RD_LAT];
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_addr_q [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LAT_W-1:0]  inflight;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + LAT_W'(tag_vld_q[i]);
    end
  end

  // A read may only be issued if the buffer can still absorb it together
  // with every read already in flight, even if nothing is popped meanwhile.
  assign credit_ok = (32'(inflight) + 32'(cnt_q) + 32'd1) <= 32'(BUF_DEPTH);
  assign issue     = (state_q == S_READ) && credit_ok;
  assign push      = tag_vld_q[RD_LAT-1];
  assign pop       = (cnt_q != '0) && out_if.out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    tag_vld_d[0]  = issue;
    tag_addr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        if (issue) begin
          // Wraps to 0 when WORDS = 2^ADDR_W; DRAIN stops further issues.
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_d == '0) && (tag_vld_d == '0)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tag_vld_q <= tag_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Datapath storage carries no reset; the valid bits above qualify it.
  always_ff @(posedge Clk) begin
    tag_addr_q <= tag_addr_d;
    if (push) begin
      buf_data_q[wr_ptr_q] <= q;
      buf_addr_q[wr_ptr_q] <= tag_addr_q[RD_LAT-1];
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && Start) csum_d = '0;
    else if (pop)                     csum_d = csum_q + out_if.out_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign ADDR             = addr_q;
  assign rden             = issue;
  assign out_if.out_data  = buf_data_q[rd_ptr_q];
  assign out_if.out_addr  = buf_addr_q[rd_ptr_q];
  assign out_if.out_valid = (cnt_q != '0);
  assign busy             = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);

endmodule
